// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit combinational ALU: accepts register-based
// commands, drives registered operands, writes results back and returns them.
module alu_cmd_sequencer #(
    parameter int DW    = 4,
    parameter int OPS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_rd,
    input  logic [1:0]       cmd_ra,
    input  logic [1:0]       cmd_rb,
    input  logic             cmd_imm_en,
    input  logic [DW-1:0]    cmd_imm,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [2:0]       alu_op,
    input  logic [DW-1:0]    alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [1:0]       res_rd,
    output logic             res_zero,
    output logic [OPS_W-1:0] ops_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] regs [4];

    logic [2:0]    op_q;
    logic [1:0]    rd_q;
    logic [1:0]    ra_q;
    logic [1:0]    rb_q;
    logic          imm_en_q;
    logic [DW-1:0] imm_q;

    logic accept;
    logic res_done;

    assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
    assign res_done = (state == RESP) && res_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (accept)   state_next = READ;
            READ:               state_next = EXEC;
            EXEC:               state_next = RESP;
            RESP: if (res_done) state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            imm_en_q  <= 1'b0;
            imm_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_zero  <= 1'b0;
            ops_count <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            if (accept) begin
                op_q     <= cmd_op;
                rd_q     <= cmd_rd;
                ra_q     <= cmd_ra;
                rb_q     <= cmd_rb;
                imm_en_q <= cmd_imm_en;
                imm_q    <= cmd_imm;
            end
            if (state == READ) begin
                alu_a  <= regs[ra_q];
                alu_b  <= imm_en_q ? imm_q : regs[rb_q];
                alu_op <= op_q;
            end
            if (state == EXEC) begin
                res_data  <= alu_out;
                res_rd    <= rd_q;
                res_zero  <= (alu_out == '0);
                res_valid <= 1'b1;
            end
            if (res_done) begin
                res_valid <= 1'b0;
                if (ops_count != '1) ops_count <= ops_count + OPS_W'(1);
            end
        end
    end

    // NOTE: the register file is reset on purpose: an abort must leave it all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (state == EXEC) begin
            regs[rd_q] <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer; a behavioural ALU
// closes the loop from alu_a/alu_b/alu_op back to alu_out.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_rd;
    logic       res_zero;
    logic [7:0] ops_count;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.DW(4), .OPS_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_zero   (res_zero),
        .ops_count  (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the team's combinational ALU.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'b000: alu_out = alu_a + alu_b;
            3'b001: alu_out = alu_a - alu_b;
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = ~alu_a;
            3'b101: alu_out = ~alu_b;
            3'b110: alu_out = alu_a ^ alu_b;
            3'b111: alu_out = ~(alu_a ^ alu_b);
            default: alu_out = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command, waits for acceptance and returns the cycles to res_valid.
    task automatic send_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                            input logic [1:0] rb, input logic ie, input logic [3:0] imm,
                            output int lat);
        int wait_cyc;
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm_en = ie; cmd_imm = imm;
        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        checks++;
        if (wait_cyc >= 20) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, wait_cyc);
        end
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_resp();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_ready, res_valid, res_data, res_rd, res_zero} !== 9'd0) begin
            errors++;
            $display("FAIL reset_res: got rdy=%b v=%b d=%0h rd=%0d z=%b, required all 0",
                     cmd_ready, res_valid, res_data, res_rd, res_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, ops_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_alu: got a=%0h b=%0h op=%0h cnt=%0d, required all 0",
                     alu_a, alu_b, alu_op, ops_count);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b required 0", cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_cmd(3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'd9, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 2", lat);
        end
        checks++;
        if ({res_data, res_rd, res_zero} !== {4'd9, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_or: got d=%0h rd=%0d z=%b, required d=9 rd=1 z=0", res_data, res_rd, res_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'd0, 4'd9, 3'b011}) begin
            errors++;
            $display("FAIL basic_alu_regs: got a=%0h b=%0h op=%0h, required a=0 b=9 op=3", alu_a, alu_b, alu_op);
        end
        finish_resp();
        send_cmd(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8, lat);
        checks++;
        if ({res_data, res_rd, res_zero} !== {4'd1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_add_wrap: got d=%0h rd=%0d z=%b, required d=1 rd=2 z=0", res_data, res_rd, res_zero);
        end
        finish_resp();
        checks++;
        if (ops_count !== 8'd2) begin
            errors++;
            $display("FAIL basic_ops_count: got %0d required 2", ops_count);
        end
    endtask

    task automatic test_sub_zero();
        int lat;
        send_cmd(3'b001, 2'd3, 2'd1, 2'd1, 1'b0, 4'hF, lat);
        checks++;
        if ({res_data, res_zero} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL sub_self: got d=%0h z=%b, required d=0 z=1", res_data, res_zero);
        end
        finish_resp();
        send_cmd(3'b011, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0, lat);
        checks++;
        if ({res_data, res_rd, res_zero} !== {4'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL sub_dependent: got d=%0h rd=%0d z=%b, required d=0 rd=0 z=1", res_data, res_rd, res_zero);
        end
        finish_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        send_cmd(3'b110, 2'd0, 2'd1, 2'd0, 1'b1, 4'hF, lat);
        // Keep a different command on the bus while the result is stalled.
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_rd = 2'd2; cmd_ra = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 4'hC;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({res_valid, res_data, res_rd, cmd_ready, alu_op} !== {1'b1, 4'h6, 2'd0, 1'b0, 3'b110}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0h rd=%0d rdy=%b op=%0h, required v=1 d=6 rd=0 rdy=0 op=6",
                         i, res_valid, res_data, res_rd, cmd_ready, alu_op);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b, required v=0 rdy=1", res_valid, cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: got rdy=%b required 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({res_valid, res_data, res_rd} !== {1'b1, 4'h8, 2'd2}) begin
            errors++;
            $display("FAIL bp_next_result: got v=%b d=%0h rd=%0d, required v=1 d=8 rd=2", res_valid, res_data, res_rd);
        end
        finish_resp();
        checks++;
        if (ops_count !== 8'd6) begin
            errors++;
            $display("FAIL bp_ops_count: got %0d required 6", ops_count);
        end
    endtask

    task automatic test_not_ops();
        int lat;
        send_cmd(3'b101, 2'd3, 2'd0, 2'd0, 1'b1, 4'b0101, lat);
        checks++;
        if (res_data !== 4'b1010) begin
            errors++;
            $display("FAIL not_b: got %b required 1010", res_data);
        end
        finish_resp();
        send_cmd(3'b100, 2'd3, 2'd1, 2'd0, 1'b1, 4'd0, lat);
        checks++;
        if (res_data !== 4'b0110) begin
            errors++;
            $display("FAIL not_a: got %b required 0110", res_data);
        end
        finish_resp();
    endtask

    task automatic test_reset_exec();
        int lat;
        cmd_valid = 1'b1; cmd_op = 3'b011; cmd_rd = 2'd1; cmd_ra = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 4'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, res_valid, res_data, res_rd, res_zero, alu_a, alu_b, alu_op, ops_count} !== 36'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b v=%b d=%0h a=%0h b=%0h op=%0h cnt=%0d, required all 0",
                     cmd_ready, res_valid, res_data, alu_a, alu_b, alu_op, ops_count);
        end
        repeat (2) tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: got v=%b required 0", res_valid);
        end
        rst_n = 1'b1;
        tick();
        send_cmd(3'b011, 2'd2, 2'd1, 2'd0, 1'b1, 4'd0, lat);
        checks++;
        if ({res_data, res_zero} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL regfile_cleared: got d=%0h z=%b, required d=0 z=1", res_data, res_zero);
        end
        finish_resp();
        checks++;
        if (ops_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_ops_count: got %0d required 1", ops_count);
        end
    endtask

    task automatic test_saturate();
        int accepts = 0;
        int last = -1;
        int bad = 0;
        int cyc = 0;
        int lat;
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 4'd1;
        while (accepts < 300 && cyc < 2000) begin
            if (cmd_ready === 1'b1) begin
                if (last >= 0 && cyc - last != 4) bad++;
                last = cyc;
                accepts++;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (accepts != 300) begin
            errors++;
            $display("FAIL sat_accepts: got %0d required 300", accepts);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_period: got %0d gaps not equal to 4, required 0", bad);
        end
        checks++;
        if (ops_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_count: got %0d required 255", ops_count);
        end
        // r0 was incremented 300 times from 0: 300 mod 16 = 12.
        send_cmd(3'b011, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, lat);
        checks++;
        if (res_data !== 4'd12) begin
            errors++;
            $display("FAIL sat_accumulate: got %0d required 12", res_data);
        end
        tick();
        res_ready = 1'b0;
        checks++;
        if ({ops_count, cmd_ready} !== {8'd255, 1'b1}) begin
            errors++;
            $display("FAIL sat_hold: got cnt=%0d rdy=%b, required cnt=255 rdy=1", ops_count, cmd_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_sub_zero();
        test_backpressure();
        test_not_ops();
        test_reset_exec();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end that feeds the team's 4-bit combinational ALU. It accepts register-based ALU commands over a valid/ready handshake and reads operands from a 4-entry, 4-bit register file. It drives registered operands and opcode to the ALU, then writes the result back to the register file. The result is also returned to the consumer over a second valid/ready handshake.

## Interface
Parameters:
- DW, 4, data width; fixed to the ALU width, no other value supported
- OPS_W, 8, width of the saturating completed-operation counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset, single clock domain
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 ~A, 101 ~B, 110 xor, 111 xnor
- cmd_rd  in  2  destination register index
- cmd_ra  in  2  operand A register index
- cmd_rb  in  2  operand B register index
- cmd_imm_en  in  1  1: operand B = cmd_imm instead of reg[cmd_rb]
- cmd_imm  in  DW  immediate operand
- alu_a  out  DW  registered operand A to ALU
- alu_b  out  DW  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_out  in  DW  combinational ALU result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DW  result value
- res_rd  out  2  destination index of result
- res_zero  out  1  res_data == 0
- ops_count  out  OPS_W  completed results, saturating

## Operation
- States: IDLE, READ, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch op, rd, ra, rb, imm_en and imm, then go to READ.
- READ:
  - alu_a <= reg[ra].
  - alu_b <= imm_en ? imm : reg[rb].
  - alu_op <= op.
  - Go to EXEC.
- EXEC:
  - Capture alu_out into res_data and reg[rd].
  - res_rd <= rd; res_zero <= (alu_out == 0); res_valid <= 1.
  - Go to RESP.
- RESP:
  - Hold res_* stable while res_valid & !res_ready.
  - On res_ready: res_valid <= 0, ops_count increments (saturates at 2^OPS_W-1), cmd_ready <= 1, go to IDLE.
- cmd_ready is registered and is 0 in READ, EXEC and RESP. cmd_valid is ignored while cmd_ready is 0.
- Register reads in READ see every prior writeback, so back-to-back dependent commands need no forwarding.
- rd == ra or rd == rb is legal; the old value is used as the operand.
- Arithmetic is modulo 2^DW: no carry or borrow out, and wrap is silent.
- alu_a, alu_b and alu_op hold their last values outside READ.

## Timing
- Reset values (rst_n low, asynchronous):
  - state IDLE.
  - cmd_ready 0, rising to 1 on the first clk edge after rst_n deasserts.
  - res_valid 0; res_data, res_rd, res_zero 0.
  - alu_a, alu_b, alu_op 0; ops_count 0.
  - Register file all 0.
- Accept edge E0 → alu_* valid after E1 → res_valid high after E2.
- Latency from accept to res_valid is 2 cycles.
- If res_ready is high at E3, cmd_ready is high after E3 and the next accept is at the earliest at E4. Peak throughput is 1 command per 4 cycles.
- res_ready high before res_valid has no effect.
- Reset asserted in any state aborts the operation: the pending result is discarded, the register file is cleared, and all outputs take their reset values immediately.
- If a writeback and reset coincide, reset wins.

## Test plan
- Reset, then cmd op=011 rd=1 ra=0 imm_en=1 imm=9 → res_valid 2 cycles after accept with res_data=9, res_rd=1, res_zero=0. Then op=000 rd=2 ra=1 imm=8 → res_data=1 (wrap), ops_count=2.
- With r1=9, cmd op=001 rd=3 ra=1 rb=1 imm_en=0 → res_data=0, res_zero=1; the following cmd op=011 ra=3 imm=0 returns 0.
- Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 → res_valid stays 1, res_data stable, cmd_ready=0, no command accepted. Raise res_ready → IDLE and accept on the following cycles.
- op=101 imm_en=1 imm=4'b0101 → res_data=4'b1010. op=100 with ra=r1=9 → res_data=4'b0110.
- Assert rst_n=0 during EXEC → all outputs 0 asynchronously, no res_valid. After release, op=011 ra=1 imm=0 → res_data=0 (register file cleared).
- Complete 300 commands with res_ready tied 1 → ops_count saturates at 255, and the cmd_ready period is exactly 4 cycles.
